// File: rtl/tdes_sequencer.sv
// Triple-DES sequencer: runs a single-DES engine three times (EDE for
// encrypt, DED with reversed keys for decrypt) and aborts a pass if the
// engine does not answer within DONE_TIMEOUT wait cycles.
module tdes_sequencer #(
   parameter int DONE_TIMEOUT = 64
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        enable,
   input  logic        encryptionType,
   input  logic [63:0] data,
   input  logic [63:0] key1,
   input  logic [63:0] key2,
   input  logic [63:0] key3,
   output logic        outputEnable,
   output logic [63:0] outputData,
   output logic        busy,
   output logic        error,
   output logic        des_start,
   output logic        des_decrypt,
   output logic [63:0] des_key,
   output logic [63:0] des_data,
   input  logic        des_done,
   input  logic [63:0] des_result
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam int             CW        = $clog2(DONE_TIMEOUT + 1);
   localparam logic [CW-1:0]  WAIT_LAST = CW'(DONE_TIMEOUT - 1);

   logic [1:0]    state;
   logic [1:0]    pass;
   logic [CW-1:0] wait_cnt;
   logic          encrypt_q;
   logic [63:0]   data_q;
   logic [63:0]   key1_q;
   logic [63:0]   key2_q;
   logic [63:0]   key3_q;
   logic [63:0]   inter_q;

   // Key for a given pass: encrypt walks key1..key3, decrypt walks key3..key1.
   function automatic logic [63:0] pass_key(input logic enc, input logic [1:0] p,
                                            input logic [63:0] k1, input logic [63:0] k2,
                                            input logic [63:0] k3);
      case (p)
         2'd0:    return enc ? k1 : k3;
         2'd1:    return k2;
         default: return enc ? k3 : k1;
      endcase
   endfunction

   // Engine direction: the middle pass runs opposite to the outer two.
   function automatic logic pass_dir(input logic enc, input logic [1:0] p);
      return enc ? (p == 2'd1) : (p != 2'd1);
   endfunction

   // Status and engine handshake follow directly from the state.
   assign busy      = (state != IDLE);
   assign des_start = (state == START);
   // First pass consumes the captured block, later passes the previous result.
   assign des_data  = (pass == 2'd0) ? data_q : inter_q;

   // Sequencer FSM, operand capture, pass chaining and timeout watchdog.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state        <= IDLE;
         pass         <= 2'd0;
         wait_cnt     <= '0;
         encrypt_q    <= 1'b0;
         data_q       <= '0;
         key1_q       <= '0;
         key2_q       <= '0;
         key3_q       <= '0;
         inter_q      <= '0;
         des_key      <= '0;
         des_decrypt  <= 1'b0;
         outputEnable <= 1'b0;
         outputData   <= '0;
         error        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  encrypt_q    <= encryptionType;
                  data_q       <= data;
                  key1_q       <= key1;
                  key2_q       <= key2;
                  key3_q       <= key3;
                  des_key      <= pass_key(encryptionType, 2'd0, key1, key2, key3);
                  des_decrypt  <= pass_dir(encryptionType, 2'd0);
                  pass         <= 2'd0;
                  outputEnable <= 1'b0;
                  error        <= 1'b0;
                  state        <= START;
               end
            end
            START: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (des_done) begin
                  if (pass == 2'd2) begin
                     outputData   <= des_result;
                     outputEnable <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     inter_q     <= des_result;
                     pass        <= pass + 2'd1;
                     des_key     <= pass_key(encrypt_q, pass + 2'd1, key1_q, key2_q, key3_q);
                     des_decrypt <= pass_dir(encrypt_q, pass + 2'd1);
                     state       <= START;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  error <= 1'b1;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdes_sequencer.sv
// Bench for tdes_sequencer: behavioural engine stubs (XOR, rotate, real DES,
// hang, done-spam) and a reference 3DES model built from the pass rules.
module tb_tdes_sequencer;

   localparam int M_XOR = 0, M_ROT = 1, M_DES = 2, M_HANG = 3, M_SPAM = 4;
   localparam int K_NORM = 0, K_RST = 1, K_TMO = 2;

   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
   localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
   localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                 41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   logic        HCLK = 1'b0;
   logic        HRESET, enable, encryptionType;
   logic [63:0] data, key1, key2, key3;
   logic        outputEnable, busy, error, des_start, des_decrypt, des_done;
   logic [63:0] outputData, des_key, des_data, des_result;

   int          total = 0;
   int          bad = 0;
   int          eng_mode = M_XOR;
   logic        eng_done_q = 1'b0;
   logic [63:0] eng_res_q = '0;

   logic [63:0] exp_key [3];
   logic [63:0] exp_din [3];
   logic        exp_dir [3];
   logic [63:0] exp_out;

   logic [63:0] mon_key [$];
   logic [63:0] mon_din [$];
   logic        mon_dir [$];
   int          dbl_start = 0;
   int          unstable = 0;
   logic        start_d = 1'b0;
   logic [63:0] snap_key = '0, snap_din = '0;
   logic        snap_dir = 1'b0;

   tdes_sequencer #(.DONE_TIMEOUT(64)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .encryptionType(encryptionType),
      .data(data), .key1(key1), .key2(key2), .key3(key3),
      .outputEnable(outputEnable), .outputData(outputData), .busy(busy), .error(error),
      .des_start(des_start), .des_decrypt(des_decrypt), .des_key(des_key), .des_data(des_data),
      .des_done(des_done), .des_result(des_result));

   always #5 HCLK = ~HCLK;

   function automatic logic [63:0] des(input logic [63:0] blk, input logic [63:0] key, input logic dec);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] ks [16];
      logic [63:0] ip, pre, res;
      logic [31:0] l, r, t, sout, fo;
      logic [47:0] e, x;
      logic [5:0]  b;
      logic [255:0] sb;
      int idx;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int rd = 0; rd < 16; rd++) begin
         for (int s = 0; s < SH_T[rd]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-PC2_T[i]];
      end
      for (int i = 0; i < 64; i++) ip[63-i] = blk[64-IP_T[i]];
      l = ip[63:32];
      r = ip[31:0];
      for (int rd = 0; rd < 16; rd++) begin
         for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
         x = e ^ ks[dec ? 15 - rd : rd];
         for (int s = 0; s < 8; s++) begin
            b   = x[47-6*s -: 6];
            sb  = SBOX[s];
            idx = int'({b[5], b[0]}) * 16 + int'(b[4:1]);
            sout[31-4*s -: 4] = sb[255-4*idx -: 4];
         end
         for (int i = 0; i < 32; i++) fo[31-i] = sout[32-P_T[i]];
         t = r;
         r = l ^ fo;
         l = t;
      end
      pre = {r, l};
      for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
      return res;
   endfunction

   // Single-DES behaviour of whichever stub engine is plugged in.
   function automatic logic [63:0] eng_fn(input int mode, input logic [63:0] d, input logic [63:0] k,
                                          input logic dec);
      logic [63:0] t;
      case (mode)
         M_DES:         return des(d, k, dec);
         M_ROT, M_SPAM: begin
            if (dec) begin t = d ^ k; return {t[7:0], t[63:8]}; end
            else return {d[55:0], d[63:56]} ^ k;
         end
         default:       return d ^ k;
      endcase
   endfunction

   // Engine stub: answers one cycle after des_start (never in hang mode).
   always @(posedge HCLK) begin
      eng_done_q <= des_start && (eng_mode != M_HANG);
      if (des_start) eng_res_q <= eng_fn(eng_mode, des_data, des_key, des_decrypt);
   end
   // Spam mode also raises done throughout IDLE and START, with a junk result.
   assign des_done   = eng_done_q | ((eng_mode == M_SPAM) && (!busy || des_start));
   assign des_result = eng_done_q ? eng_res_q : 64'hBADC0FFEE0DDF00D;

   // Record each engine request and watch operands while the engine is working.
   always @(negedge HCLK) begin
      if (des_start) begin
         mon_key.push_back(des_key);
         mon_din.push_back(des_data);
         mon_dir.push_back(des_decrypt);
         snap_key = des_key;
         snap_din = des_data;
         snap_dir = des_decrypt;
      end else if (busy && (des_key !== snap_key || des_data !== snap_din || des_decrypt !== snap_dir)) begin
         unstable++;
      end
      if (des_start && start_d) dbl_start++;
      start_d = des_start;
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference 3DES: ordered key/direction schedule applied through the stub.
   task automatic model(input int mode, input logic enc, input logic [63:0] d,
                        input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3);
      logic [63:0] x;
      if (enc) begin
         exp_key[0] = k1; exp_key[1] = k2; exp_key[2] = k3;
         exp_dir[0] = 1'b0; exp_dir[1] = 1'b1; exp_dir[2] = 1'b0;
      end else begin
         exp_key[0] = k3; exp_key[1] = k2; exp_key[2] = k1;
         exp_dir[0] = 1'b1; exp_dir[1] = 1'b0; exp_dir[2] = 1'b1;
      end
      x = d;
      for (int p = 0; p < 3; p++) begin
         exp_din[p] = x;
         x = eng_fn(mode, x, exp_key[p], exp_dir[p]);
      end
      exp_out = x;
   endtask

   task automatic run_op(input string tag, input int mode, input logic enc, input logic [63:0] d,
                         input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3,
                         input int kind, input int inj, input int rst);
      int cyc;
      eng_mode = mode;
      model(mode, enc, d, k1, k2, k3);
      mon_key.delete();
      mon_din.delete();
      mon_dir.delete();
      encryptionType = enc; data = d; key1 = k1; key2 = k2; key3 = k3;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      encryptionType = ~enc;
      data = {$urandom, $urandom}; key1 = {$urandom, $urandom};
      key2 = {$urandom, $urandom}; key3 = {$urandom, $urandom};
      cyc = 1;
      chk({tag, ".c1_oe"}, 64'(outputEnable), 64'd0);
      chk({tag, ".c1_err"}, 64'(error), 64'd0);
      chk({tag, ".c1_busy"}, 64'(busy), 64'd1);
      chk({tag, ".c1_start"}, 64'(des_start), 64'd1);
      while (cyc < 200 && !outputEnable && !error) begin
         enable = (cyc == inj) || (cyc == rst);
         HRESET = (cyc == rst);
         if (kind == K_TMO && cyc == 65) begin
            chk({tag, ".c65_busy"}, 64'(busy), 64'd1);
            chk({tag, ".c65_err"}, 64'(error), 64'd0);
         end
         tick();
         cyc++;
         enable = 1'b0;
         HRESET = 1'b0;
         if (rst != 0 && cyc > rst) break;
      end
      if (kind == K_NORM) begin
         chk({tag, ".latency"}, 64'(cyc), 64'd7);
         chk({tag, ".out"}, outputData, exp_out);
         chk({tag, ".oe"}, 64'(outputEnable), 64'd1);
         chk({tag, ".busy_end"}, 64'(busy), 64'd0);
         chk({tag, ".nstart"}, 64'(mon_key.size()), 64'd3);
         if (mon_key.size() == 3) begin
            for (int p = 0; p < 3; p++) begin
               chk($sformatf("%s.key%0d", tag, p), mon_key[p], exp_key[p]);
               chk($sformatf("%s.dir%0d", tag, p), 64'(mon_dir[p]), 64'(exp_dir[p]));
               chk($sformatf("%s.din%0d", tag, p), mon_din[p], exp_din[p]);
            end
         end
         repeat (3) tick();
         chk({tag, ".oe_hold"}, 64'(outputEnable), 64'd1);
         chk({tag, ".out_hold"}, outputData, exp_out);
      end else if (kind == K_RST) begin
         chk({tag, ".rst_cyc"}, 64'(cyc), 64'(rst + 1));
         chk({tag, ".rst_busy"}, 64'(busy), 64'd0);
         chk({tag, ".rst_oe"}, 64'(outputEnable), 64'd0);
         chk({tag, ".rst_out"}, outputData, 64'd0);
         chk({tag, ".rst_key"}, des_key, 64'd0);
         chk({tag, ".rst_din"}, des_data, 64'd0);
         chk({tag, ".rst_dir"}, 64'(des_decrypt), 64'd0);
         repeat (4) tick();
         chk({tag, ".post_oe"}, 64'(outputEnable), 64'd0);
         chk({tag, ".post_busy"}, 64'(busy), 64'd0);
         chk({tag, ".post_out"}, outputData, 64'd0);
      end else begin
         chk({tag, ".tmo_cyc"}, 64'(cyc), 64'd66);
         chk({tag, ".tmo_err"}, 64'(error), 64'd1);
         chk({tag, ".tmo_busy"}, 64'(busy), 64'd0);
         chk({tag, ".tmo_oe"}, 64'(outputEnable), 64'd0);
         chk({tag, ".tmo_nstart"}, 64'(mon_key.size()), 64'd1);
      end
   endtask

   initial begin
      logic [63:0] enc_res;
      HRESET = 1'b1; enable = 1'b1; encryptionType = 1'b1;
      data = 64'h0123456789ABCDEF; key1 = 64'h1; key2 = 64'h2; key3 = 64'h4;
      tick();
      tick();
      chk("reset.oe", 64'(outputEnable), 64'd0);
      chk("reset.out", outputData, 64'd0);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.err", 64'(error), 64'd0);
      chk("reset.start", 64'(des_start), 64'd0);
      chk("reset.key", des_key, 64'd0);
      chk("reset.din", des_data, 64'd0);
      chk("reset.dir", 64'(des_decrypt), 64'd0);
      HRESET = 1'b0; enable = 1'b0;
      tick();

      run_op("xor_enc", M_XOR, 1'b1, 64'h0123456789ABCDEF, 64'h1, 64'h2, 64'h4, K_NORM, 0, 0);
      chk("xor_enc.const", outputData, 64'h0123456789ABCDE8);
      run_op("xor_dec", M_XOR, 1'b0, 64'h0123456789ABCDEF, 64'h1, 64'h2, 64'h4, K_NORM, 0, 0);
      chk("xor_dec.const", outputData, 64'h0123456789ABCDE8);

      run_op("des_enc", M_DES, 1'b1, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1,
             64'h133457799BBCDFF1, 64'h133457799BBCDFF1, K_NORM, 0, 0);
      chk("des_enc.const", outputData, 64'h85E813540F0AB405);
      enc_res = outputData;
      run_op("des_dec", M_DES, 1'b0, enc_res, 64'h133457799BBCDFF1,
             64'h133457799BBCDFF1, 64'h133457799BBCDFF1, K_NORM, 0, 0);
      chk("des_dec.const", outputData, 64'h0123456789ABCDEF);

      run_op("timeout", M_HANG, 1'b1, 64'hA5A5A5A55A5A5A5A, 64'h11, 64'h22, 64'h44, K_TMO, 0, 0);
      run_op("after_tmo", M_ROT, 1'b1, 64'hA5A5A5A55A5A5A5A, 64'h11, 64'h22, 64'h44, K_NORM, 0, 0);

      run_op("en_pass1", M_ROT, 1'b1, 64'hFEEDFACECAFEBEEF, 64'h1111, 64'h2222, 64'h3333, K_NORM, 3, 0);
      run_op("en_wait1", M_ROT, 1'b0, 64'hFEEDFACECAFEBEEF, 64'h1111, 64'h2222, 64'h3333, K_NORM, 4, 0);
      run_op("rst_p2s", M_ROT, 1'b1, 64'h0F0F0F0FF0F0F0F0, 64'h5, 64'h6, 64'h7, K_RST, 0, 5);
      run_op("rst_p2w", M_XOR, 1'b1, 64'h0F0F0F0FF0F0F0F0, 64'h5, 64'h6, 64'h7, K_RST, 0, 6);

      run_op("spam_enc", M_SPAM, 1'b1, 64'h0123456789ABCDEF, 64'h1, 64'h2, 64'h4, K_NORM, 0, 0);
      run_op("spam_dec", M_SPAM, 1'b0, 64'h76543210FEDCBA98, 64'h9, 64'hA, 64'hB, K_NORM, 0, 0);

      for (int n = 0; n < 12; n++) begin
         run_op($sformatf("rnd%0d", n), (n % 2 == 0) ? M_ROT : M_DES, 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, K_NORM, 0, 0);
      end

      chk("double_start", 64'(dbl_start), 64'd0);
      chk("operand_stable", 64'(unstable), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdes_sequencer.md
TDES_SEQUENCER -- requirements
Module: tdes_sequencer

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 64, meaning the maximum number of WAIT cycles allowed per DES pass before abort.
REQ-002 SHALL have port HCLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port HRESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port enable  input  1  one-cycle start pulse from the AHB slave controller.
REQ-005 SHALL have port encryptionType  input  1  mode select: 1 = encrypt, 0 = decrypt.
REQ-006 SHALL have ports data, key1, key2, key3  input  64 each  plaintext/ciphertext block and three DES keys.
REQ-007 SHALL have port outputEnable  output  1  result-valid level to the AHB slave controller.
REQ-008 SHALL have port outputData  output  64  Triple-DES result.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port error  output  1  sticky timeout flag.
REQ-011 SHALL have port des_start  output  1  one-cycle start to the single-DES engine.
REQ-012 SHALL have port des_decrypt  output  1  engine direction: 1 = decrypt.
REQ-013 SHALL have ports des_key, des_data  output  64 each  engine key and input block.
REQ-014 SHALL have port des_done  input  1  engine result-valid pulse.
REQ-015 SHALL have port des_result  input  64  engine output block.

Function
REQ-016 SHALL implement FSM states IDLE, START and WAIT, plus a 2-bit pass counter (0..2).
REQ-017 In IDLE, on enable=1, SHALL capture data, key1-3 and encryptionType into internal registers, clear outputEnable and error, set pass=0, and go to START.
REQ-018 SHALL ignore enable while not in IDLE: no recapture, no queueing.
REQ-019 SHALL use this pass schedule for encrypt: pass0 (key1, des_decrypt=0), pass1 (key2, 1), pass2 (key3, 0).
REQ-020 SHALL use this pass schedule for decrypt: pass0 (key3, des_decrypt=1), pass1 (key2, 0), pass2 (key1, 1).
REQ-021 SHALL drive des_data from the captured data in pass0, and from the intermediate register (previous des_result) in pass1 and pass2.
REQ-022 In START, SHALL assert des_start for exactly one cycle and then go to WAIT.
REQ-023 SHALL hold des_key, des_data and des_decrypt stable from START until des_done is accepted.
REQ-024 SHALL sample des_done only in WAIT; des_done in IDLE or START SHALL be ignored.
REQ-025 In WAIT with des_done=1 and pass<2, SHALL latch des_result into the intermediate register, increment pass, and go to START.
REQ-026 In WAIT with des_done=1 and pass=2, SHALL register des_result into outputData, set outputEnable=1, and go to IDLE.
REQ-027 SHALL hold outputEnable high and outputData unchanged until the next accepted enable or reset.
REQ-028 SHALL count WAIT cycles per pass, restarting the count at each START.
REQ-029 When the WAIT count reaches DONE_TIMEOUT without des_done, SHALL set error=1, leave outputEnable=0, and go to IDLE.
REQ-030 SHALL drive busy=1 in START and WAIT, and 0 in IDLE.
REQ-031 Latency: with des_done in the first WAIT cycle of every pass, enable sampled at edge 0 SHALL give outputEnable=1 in cycle 7 (6 busy cycles).

Reset
REQ-032 On HRESET=1 at a clock edge, SHALL go to IDLE, with pass=0 and the WAIT count at 0.
REQ-033 On HRESET=1, SHALL clear outputEnable, busy, error and des_start, and clear outputData, des_key, des_data, des_decrypt and the intermediate register to 0.
REQ-034 Reset mid-operation SHALL abort the operation with no output; any later des_done SHALL be ignored.
REQ-035 Reset SHALL take priority over enable and des_done in the same cycle.

Verification
REQ-036 Bench with XOR stub engine (result = des_data ^ des_key, done 1 cycle after start), encrypt, data=0x0123456789ABCDEF, keys 0x1/0x2/0x4 -> outputData=0x0123456789ABCDE8, des_decrypt sequence 0,1,0, outputEnable in cycle 7.
REQ-037 Same stub engine, decrypt, same values -> des_key sequence 0x4, 0x2, 0x1, des_decrypt sequence 1,0,1, outputData=0x0123456789ABCDE8.
REQ-038 Real DES engine, key1=key2=key3=0x133457799BBCDFF1, data=0x0123456789ABCDEF, encrypt -> 0x85E813540F0AB405; decrypting that result -> 0x0123456789ABCDEF.
REQ-039 Stub engine that never asserts done, DONE_TIMEOUT=64 -> error=1 after 64 WAIT cycles, busy=0, outputEnable=0; a new enable clears error and runs normally.
REQ-040 enable pulsed during pass1 with different data -> ignored, result matches the first data; HRESET pulsed in pass2 -> busy=0, outputEnable=0, no output produced.
REQ-041 Stub engine asserting des_done in START and every cycle of IDLE -> ignored; only the done in WAIT advances the pass.
